hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; it sequences the IF/ID/EX boundary and complements the EX-stage forwarding unit.
- Detects hazards that forwarding cannot cover: load-use, branch operands resolved in ID, and accesses to the multi-cycle MDU (mult/div) while it is busy.
- Drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush for taken branches.
- Holds the MDU busy FSM/latency counter and a saturating stall-cycle performance counter.

Parameters:
MDU_LAT, 32, MDU occupancy in cycles after issue (legal range >=1)
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
IFID_regRs  in  5  rs of the instruction in ID
IFID_regRt  in  5  rt of the instruction in ID
IFID_usesRt  in  1  ID instruction reads rt as a source
IFID_isBranch  in  1  ID instruction is beq/bne (compares in ID)
IFID_isMdu  in  1  ID instruction is mult/multu/div/divu
IFID_readsHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
IDEX_memRead  in  1  EX instruction is a load
IDEX_regWrite  in  1  EX instruction writes the register file
IDEX_regRd  in  5  EX destination register (already muxed rt/rd)
EXMEM_memRead  in  1  MEM instruction is a load
EXMEM_regRd  in  5  MEM destination register
branch_taken  in  1  ID branch comparison result, valid this cycle
pc_write  out  1  PC load enable
IFID_write  out  1  IF/ID register load enable
IDEX_bubble  out  1  force ID/EX control to zero (nop)
IFID_flush  out  1  zero IF/ID on next edge
stall_cause  out  2  0 none, 1 load-use, 2 branch, 3 mdu
mdu_busy  out  1  MDU FSM in BUSY
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async): FSM=IDLE, mdu_cnt=0, stall_count=0.
- With no hazard: pc_write=1, IFID_write=1, all other outputs 0.
- Match functions:
  - mX(r) = (r!=0) & (r==IFID_regRs | (IFID_usesRt & r==IFID_regRt)).
- Combinational hazards, evaluated every cycle:
  - lu = IDEX_memRead & mX(IDEX_regRd)
  - br = IFID_isBranch & ((IDEX_regWrite & mX(IDEX_regRd)) | (EXMEM_memRead & mX(EXMEM_regRd)))
  - md = mdu_busy & (IFID_isMdu | IFID_readsHiLo)
- stall = lu | br | md.
  - When stall=1: pc_write=0, IFID_write=0, IDEX_bubble=1.
  - stall_cause priority: lu(1) > br(2) > md(3).
  - A branch behind a load stalls 2 cycles: first via IDEX, then via EXMEM.
- IFID_flush = branch_taken & IFID_isBranch & ~stall. A taken branch whose operands are hazarded is never flushed early.
- MDU FSM (registered):
  - IDLE -> BUSY when IFID_isMdu & ~stall. That cycle is the issue cycle; load mdu_cnt = MDU_LAT-1.
  - BUSY: mdu_cnt decrements each cycle; when mdu_cnt==0, next state is IDLE.
  - mdu_busy = (state==BUSY), so BUSY lasts exactly MDU_LAT cycles.
  - An MDU op in ID during BUSY stalls (md) and issues on the first IDLE cycle; there is no back-to-back overlap.
- stall_count increments on every posedge where stall=1 and saturates at all-ones (no wrap).
- Reset mid-BUSY: returns to IDLE immediately, and the dependent instruction is released on the first cycle after reset deasserts.
- All outputs except the registered FSM and counter are combinational from current inputs and state; zero-latency detection is required.

Decomposition:
- Shared pipeline package holds:
  - stall_cause encodings: CAUSE_NONE/LU/BR/MDU.
  - MDU FSM state constants: ST_IDLE/ST_BUSY.
  - Register 0 constant.
- One natural sub-module, mdu_busy_timer: FSM plus mdu_cnt, with inputs issue/clk/rst and output busy.
- Hazard equations stay in the top level.

Test Plan:
- lw $2 in EX, add $3,$2,$4 in ID:
  - Stall cycle: lu=1 -> pc_write=0, IFID_write=0, IDEX_bubble=1, stall_cause=1 for exactly 1 cycle.
  - Next cycle: EXMEM holds the load, add has no branch -> no stall; stall_count=1.
- Load into $0 with a dependent reader -> no stall, all outputs at defaults.
- lw $5 then beq $5,$6:
  - Cycle 1: stalls via IDEX (cause 1 takes priority over 2).
  - Cycle 2: stalls via EXMEM (cause 2).
  - Cycle 3: branch_taken=1 -> IFID_flush=1, pc_write=1; stall_count=2.
- add $7 then beq $7 with branch_taken=1:
  - Stall cycle: IFID_flush=0, stall_cause=2.
  - Next cycle: IFID_flush=1.
- MDU_LAT=4: mult issues at cycle t, mflo enters ID at t+1:
  - mdu_busy=1 during t+1..t+4, stall_cause=3 during those cycles.
  - mflo proceeds at t+5; stall_count=4.
- Reset mid-operation: assert rst during BUSY (mdu_cnt=2) -> mdu_busy=0 and stall_count=0 asynchronously; mflo is not stalled after reset.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared encodings and the register-match helper for the hazard controller
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_LU   = 2'd1,
        CAUSE_BR   = 2'd2,
        CAUSE_MDU  = 2'd3
    } cause_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a producer register r feeds a source of the ID instruction; $0 never creates a dependency
    function automatic logic reg_match(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mdu_busy_timer.sv
// mdu_busy_timer: tracks MDU occupancy, busy for exactly MDU_LAT cycles after an issue
//   clk   : clock
//   rst   : asynchronous active-high reset
//   issue : an MDU op leaves ID this cycle
//   busy  : MDU is occupied
module mdu_busy_timer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic busy
);

    localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(MDU_LAT - 1);

    mdu_state_e    state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt counts remaining BUSY cycles minus one, so the cycle with cnt==0 is the last busy one
    always_comb begin
        state_next = (state == ST_IDLE) ? (issue ? ST_BUSY : ST_IDLE)
                                        : ((cnt == '0) ? ST_IDLE : ST_BUSY);
        cnt_next   = (state == ST_IDLE) ? (issue ? LOAD : cnt)
                                        : ((cnt == '0) ? cnt : cnt - CW'(1));
    end

    assign busy = (state == ST_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / ID-branch / MDU-busy stall and flush control for the IF/ID/EX boundary
//   inputs  : ID instruction sources and class, EX and MEM producer info, branch_taken
//   outputs : pc_write, IFID_write, IDEX_bubble, IFID_flush, stall_cause, mdu_busy,
//             stall_count (saturating number of stalled cycles)
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFID_regRs,
    input  logic [4:0]       IFID_regRt,
    input  logic             IFID_usesRt,
    input  logic             IFID_isBranch,
    input  logic             IFID_isMdu,
    input  logic             IFID_readsHiLo,
    input  logic             IDEX_memRead,
    input  logic             IDEX_regWrite,
    input  logic [4:0]       IDEX_regRd,
    input  logic             EXMEM_memRead,
    input  logic [4:0]       EXMEM_regRd,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             IFID_write,
    output logic             IDEX_bubble,
    output logic             IFID_flush,
    output logic [1:0]       stall_cause,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_count
);

    logic   idex_hit, exmem_hit, lu, br, md, stall;
    cause_e cause;

    assign idex_hit  = reg_match(IDEX_regRd, IFID_regRs, IFID_regRt, IFID_usesRt);
    assign exmem_hit = reg_match(EXMEM_regRd, IFID_regRs, IFID_regRt, IFID_usesRt);

    assign lu    = IDEX_memRead & idex_hit;
    // branches compare in ID, so any EX result or a MEM-stage load is still unavailable
    assign br    = IFID_isBranch & ((IDEX_regWrite & idex_hit) | (EXMEM_memRead & exmem_hit));
    assign md    = mdu_busy & (IFID_isMdu | IFID_readsHiLo);
    assign stall = lu | br | md;

    assign cause = lu ? CAUSE_LU : br ? CAUSE_BR : md ? CAUSE_MDU : CAUSE_NONE;

    assign pc_write    = ~stall;
    assign IFID_write  = ~stall;
    assign IDEX_bubble = stall;
    assign IFID_flush  = branch_taken & IFID_isBranch & ~stall;
    assign stall_cause = cause;

    mdu_busy_timer #(.MDU_LAT(MDU_LAT)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .issue (IFID_isMdu & ~stall),
        .busy  (mdu_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule
